ram_byte_packer: RTL

//  Upstream write-side stage for the 512x16 dual-clock inferred RAM.

---
 rtl/ram_packer_pkg.sv | 14 +
 rtl/ram_byte_packer_if.sv | 30 +++
 rtl/ram_byte_packer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_packer_pkg.sv
// Shared types and lane-enable constants for the RAM write-side byte packer.
package ram_packer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi
  } state_e;

  localparam logic [1:0] WEN_LO   = 2'b01;
  localparam logic [1:0] WEN_HI   = 2'b10;
  localparam logic [1:0] WEN_BOTH = 2'b11;

endpackage

// File: rtl/ram_byte_packer_if.sv
// Byte-stream input, packet control and RAM write-port bundle for ram_byte_packer.
interface ram_byte_packer_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 10
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] wa;
  logic [15:0]       wd;
  logic [1:0]        wen;
  logic              done;
  logic              wrapped;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output start, start_addr, s_data, s_valid, s_last,
    input  s_ready, wa, wd, wen, done, wrapped, wr_count
  );

  modport slave (
    input  start, start_addr, s_data, s_valid, s_last,
    output s_ready, wa, wd, wen, done, wrapped, wr_count
  );

endinterface

// File: rtl/ram_byte_packer.sv
// Packs a valid/ready byte stream into 16-bit RAM writes with byte-lane enables.
// Define RAM_PACKER_SWAP_EN to place the first byte of each pair in the upper lane.
module ram_byte_packer
  import ram_packer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DATA_DEPTH = 512,
  parameter int unsigned CNT_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  ram_byte_packer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DATA_DEPTH - 1);

  state_e             state_q, state_d;
  logic [7:0]         held_q, held_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0]  wa_q, wa_d;
  logic [15:0]        wd_q, wd_d;
  logic [1:0]         wen_q, wen_d;
  logic               done_q, done_d;
  logic               wrapped_q, wrapped_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic        accept;
  logic        issue;
  logic [15:0] issue_data;
  logic [1:0]  issue_wen;
  logic [15:0] full_data;
  logic [15:0] part_data;
  logic [1:0]  part_wen;

`ifdef RAM_PACKER_SWAP_EN
  assign full_data = {held_q, bus.s_data};
  assign part_data = {bus.s_data, 8'h00};
  assign part_wen  = WEN_HI;
`else
  assign full_data = {bus.s_data, held_q};
  assign part_data = {8'h00, bus.s_data};
  assign part_wen  = WEN_LO;
`endif

  assign bus.s_ready  = (state_q != StIdle);
  assign accept       = bus.s_valid & bus.s_ready;
  assign bus.wa       = wa_q;
  assign bus.wd       = wd_q;
  assign bus.wen      = wen_q;
  assign bus.done     = done_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.wr_count = cnt_q;

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    ptr_d      = ptr_q;
    wa_d       = wa_q;
    wd_d       = wd_q;
    wen_d      = 2'b00;
    done_d     = 1'b0;
    wrapped_d  = wrapped_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_data = full_data;
    issue_wen  = WEN_BOTH;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          ptr_d     = bus.start_addr;
          cnt_d     = '0;
          wrapped_d = 1'b0;
          state_d   = StLo;
        end
      end
      StLo: begin
        if (accept) begin
          held_d = bus.s_data;
          if (bus.s_last) begin
            issue      = 1'b1;
            issue_data = part_data;
            issue_wen  = part_wen;
            done_d     = 1'b1;
            state_d    = StIdle;
          end else begin
            state_d = StHi;
          end
        end
      end
      StHi: begin
        if (accept) begin
          issue   = 1'b1;
          done_d  = bus.s_last;
          state_d = bus.s_last ? StIdle : StLo;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      wa_d  = ptr_q;
      wd_d  = issue_data;
      wen_d = issue_wen;
      if (ptr_q == LastAddr) begin
        ptr_d     = '0;
        wrapped_d = 1'b1;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      // Counter saturates rather than rolling over.
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      held_q    <= 8'h00;
      ptr_q     <= '0;
      wa_q      <= '0;
      wd_q      <= 16'h0000;
      wen_q     <= 2'b00;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      ptr_q     <= ptr_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      wen_q     <= wen_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
